// File: rtl/des_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : des_run_ctrl
// Brief    : Run controller and counter collector for an array of des_blocks.
//            Optional abort input enabled by DES_RUN_CTRL_ABORT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module des_run_ctrl #(
    parameter int NUM_BLOCKS    = 4,
    parameter int COUNT_W       = 10,
    parameter int RUN_W         = 32,
    parameter int CLEAR_CYCLES  = 2,
    parameter int DRAIN_TIMEOUT = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [63:0]                   cmd_seed,
    input  logic [RUN_W-1:0]              cmd_run_len,
    output logic                          blk_rst_n,
    output logic                          blk_start,
    output logic [64*NUM_BLOCKS-1:0]      blk_seed,
    input  logic [COUNT_W*NUM_BLOCKS-1:0] blk_counter,
    input  logic [NUM_BLOCKS-1:0]         blk_valid,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [COUNT_W+3:0]            res_total,
    output logic                          res_error
`ifdef DES_RUN_CTRL_ABORT_EN
    ,
    input  logic                          abort
`endif
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CLEAR  = 3'd1;
    localparam logic [2:0] S_RUN    = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_ACCUM  = 3'd4;
    localparam logic [2:0] S_RESULT = 3'd5;

    localparam logic [RUN_W-1:0] C_CLR_LAST   = RUN_W'(CLEAR_CYCLES - 1);
    localparam logic [RUN_W-1:0] C_DRAIN_LAST = RUN_W'(DRAIN_TIMEOUT - 1);
    localparam logic [3:0]       C_LAST_BLK   = 4'(NUM_BLOCKS - 1);

    logic [2:0]         r_state;
    logic [RUN_W-1:0]   r_cnt;
    logic [RUN_W-1:0]   r_run_len;
    logic [59:0]        r_seed;
    logic [3:0]         r_blk;
    logic [COUNT_W+3:0] r_acc;
    logic               r_err;
    logic [COUNT_W-1:0] w_cnt_sel;
    logic               w_unused_seed;

    // Low seed nibble is replaced by the block index, so it is never stored.
    assign w_unused_seed = ^cmd_seed[3:0];
    assign w_cnt_sel     = blk_counter[int'(r_blk)*COUNT_W +: COUNT_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_run_len <= '0;
            r_seed    <= '0;
            r_blk     <= '0;
            r_acc     <= '0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_seed    <= cmd_seed[63:4];
                        r_run_len <= cmd_run_len;
                        r_acc     <= '0;
                        r_err     <= 1'b0;
                        r_blk     <= '0;
                        r_cnt     <= C_CLR_LAST;
                        r_state   <= (cmd_run_len == '0) ? S_RESULT : S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    if (r_cnt == '0) begin
                        r_cnt   <= r_run_len - RUN_W'(1);
                        r_state <= S_RUN;
                    end else begin
                        r_cnt <= r_cnt - RUN_W'(1);
                    end
                end
                S_RUN: begin
                    if (r_cnt == '0) begin
                        r_state <= S_DRAIN;
                    end else begin
                        r_cnt <= r_cnt - RUN_W'(1);
                    end
                end
                S_DRAIN: begin
                    // All-valid takes priority over a simultaneous timeout.
                    if (&blk_valid) begin
                        r_state <= S_ACCUM;
                    end else if (r_cnt == C_DRAIN_LAST) begin
                        r_err   <= 1'b1;
                        r_state <= S_ACCUM;
                    end else begin
                        r_cnt <= r_cnt + RUN_W'(1);
                    end
                end
                S_ACCUM: begin
                    r_acc <= r_acc + {4'b0000, w_cnt_sel};
                    if (r_blk == C_LAST_BLK) begin
                        r_state <= S_RESULT;
                    end else begin
                        r_blk <= r_blk + 4'd1;
                    end
                end
                S_RESULT: begin
                    if (res_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
`ifdef DES_RUN_CTRL_ABORT_EN
            if (abort && (r_state == S_RUN || r_state == S_DRAIN)) begin
                r_state <= S_RESULT;
                r_acc   <= '0;
                r_err   <= 1'b1;
            end
`endif
            // Leaving DRAIN counter zeroed for the timeout count.
            if (r_state == S_RUN && r_cnt == '0) begin
                r_cnt <= '0;
            end
        end
    end

    generate
        for (genvar i = 0; i < NUM_BLOCKS; i++) begin : g_seed
            assign blk_seed[64*i +: 64] = {r_seed, 4'(i)};
        end
    endgenerate

    assign cmd_ready = (r_state == S_IDLE) && !rst;
    assign blk_rst_n = !rst && (r_state != S_CLEAR);
    assign blk_start = (r_state == S_RUN);
    assign res_valid = (r_state == S_RESULT);
    assign res_total = r_acc;
    assign res_error = r_err;

endmodule
`default_nettype wire

// File: tb/tb_des_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_des_run_ctrl
// Brief    : Scoreboard bench for des_run_ctrl with modelled des_blocks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_des_run_ctrl;

    localparam int NB  = 4;
    localparam int CW  = 10;
    localparam int RW  = 32;
    localparam int CLR = 2;
    localparam int DT  = 64;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            cmd_valid = 1'b0;
    logic            cmd_ready;
    logic [63:0]     cmd_seed = '0;
    logic [RW-1:0]   cmd_run_len = '0;
    logic            blk_rst_n;
    logic            blk_start;
    logic [64*NB-1:0] blk_seed;
    logic [CW*NB-1:0] blk_counter;
    logic [NB-1:0]   blk_valid;
    logic            res_valid;
    logic            res_ready = 1'b0;
    logic [CW+3:0]   res_total;
    logic            res_error;
`ifdef DES_RUN_CTRL_ABORT_EN
    logic            abort = 1'b0;
`endif

    des_run_ctrl #(
        .NUM_BLOCKS(NB), .COUNT_W(CW), .RUN_W(RW),
        .CLEAR_CYCLES(CLR), .DRAIN_TIMEOUT(DT)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_seed(cmd_seed), .cmd_run_len(cmd_run_len),
        .blk_rst_n(blk_rst_n), .blk_start(blk_start), .blk_seed(blk_seed),
        .blk_counter(blk_counter), .blk_valid(blk_valid),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_total(res_total), .res_error(res_error)
`ifdef DES_RUN_CTRL_ABORT_EN
        , .abort(abort)
`endif
    );

    always #5 clk = ~clk;

    // Block model: each block reports valid dly_a[i] cycles after start falls.
    int  cnt_a[NB];
    int  dly_a[NB];
    int  since = 0;
    bit  ran = 1'b0;

    always @(posedge clk) begin
        if (!blk_rst_n) begin
            ran   <= 1'b0;
            since <= 0;
        end else if (blk_start) begin
            ran   <= 1'b1;
            since <= 0;
        end else if (since < 5000) begin
            since <= since + 1;
        end
    end

    always_comb begin
        blk_counter = '0;
        blk_valid   = '0;
        for (int i = 0; i < NB; i++) begin
            blk_counter[i*CW +: CW] = CW'(cnt_a[i]);
            blk_valid[i]            = ran && (since >= dly_a[i]);
        end
    end

    typedef struct {
        logic [63:0] seed;
        int          len;
        int          total;
        bit          err;
        int          acc_cyc;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   hold_until = 0;
    int   tmo_cnt = 0;
    int   tmo_seen = 0;
    logic rst_q = 1'b1;
    logic rst_qq = 1'b1;

    always @(posedge clk) begin
        rst_q  <= rst;
        rst_qq <= rst_q;
    end

    task automatic chk(input bit ok, input string name, input longint act, input longint exp_v);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Monitor / scoreboard
    int           nclr = 0;
    int           nstart = 0;
    bit           seed_done = 0;
    bit           first_v = 0;
    bit           pv = 0;
    bit           pr = 0;
    bit           perr = 0;
    bit           hs_prev = 0;
    logic [CW+3:0] ptot = '0;

    always @(negedge clk) begin
        cyc++;
        if (tmo_cnt != tmo_seen) begin
            tmo_seen = tmo_cnt;
            chk(1'b0, "watchdog", 0, 1);
        end
        if (rst_q) begin
            chk(blk_start === 1'b0, "rst_blk_start", blk_start, 0);
            chk(res_valid === 1'b0, "rst_res_valid", res_valid, 0);
            if (rst) chk(blk_rst_n === 1'b0, "rst_blk_rst_n", blk_rst_n, 0);
            q.delete();
            nclr = 0; nstart = 0; seed_done = 0; first_v = 0;
            pv = 0; pr = 0; hs_prev = 0;
        end else begin
            if (rst_qq) begin
                chk(cmd_ready === 1'b1, "post_rst_cmd_ready", cmd_ready, 1);
                chk(res_total === '0, "post_rst_total", res_total, 0);
                chk(res_error === 1'b0, "post_rst_error", res_error, 0);
            end
            if (!blk_rst_n) nclr++;
            if (blk_start) nstart++;
            if (blk_start && !seed_done && q.size() > 0) begin
                bit ok = 1'b1;
                for (int i = 0; i < NB; i++)
                    if (blk_seed[64*i +: 64] !== {q[0].seed[63:4], 4'(i)}) ok = 1'b0;
                chk(ok, "blk_seed", ok, 1);
                seed_done = 1'b1;
            end
            if (hs_prev) begin
                chk(cmd_ready === 1'b1, "idle_after_hs", cmd_ready, 1);
                chk(res_valid === 1'b0, "valid_drop_after_hs", res_valid, 0);
            end
            hs_prev = 1'b0;
            if (res_valid) begin
                chk(cmd_ready === 1'b0, "cmd_ready_in_result", cmd_ready, 0);
                if (pv && !pr) begin
                    chk(res_total === ptot, "stable_total", res_total, ptot);
                    chk(res_error === perr, "stable_error", res_error, perr);
                end
                if (!first_v) begin
                    first_v = 1'b1;
                    if (q.size() > 0 && q[0].len == 0)
                        chk((cyc - q[0].acc_cyc) <= 2, "zero_len_latency", cyc - q[0].acc_cyc, 2);
                end
                if (res_ready) begin
                    if (q.size() == 0) begin
                        chk(1'b0, "unexpected_result", res_total, -1);
                    end else begin
                        exp_t e;
                        e = q.pop_front();
                        chk(res_total === (CW+4)'(e.total), "res_total", res_total, e.total);
                        chk(res_error === e.err, "res_error", res_error, e.err);
                        chk(nclr == ((e.len == 0) ? 0 : CLR), "clear_cycles", nclr, (e.len == 0) ? 0 : CLR);
                        chk(nstart == e.len, "start_cycles", nstart, e.len);
                    end
                    nclr = 0; nstart = 0; seed_done = 0; first_v = 0;
                    hs_prev = 1'b1;
                end
            end
            pv = res_valid; pr = res_ready; ptot = res_total; perr = res_error;
        end
    end

    // Result consumer: random ready, forced low while a hold window is open.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            res_ready = (cyc < hold_until) ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    task automatic issue(input exp_t e);
        bit got = 1'b0;
        @(posedge clk);
        #1;
        cmd_seed    = e.seed;
        cmd_run_len = RW'(e.len);
        cmd_valid   = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (cmd_ready) begin
                got = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        if (!got) tmo_cnt++;
        else begin
            e.acc_cyc = cyc;
            q.push_back(e);
        end
    endtask

    task automatic wait_done();
        bit done = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (q.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            tmo_cnt++;
            q.delete();
        end
    endtask

    // Reference: sum of block counters; error iff the slowest block misses the window.
    function automatic exp_t model(input logic [63:0] seed, input int len);
        exp_t e;
        int   mx = 0;
        e.seed = seed; e.len = len; e.total = 0; e.err = 1'b0; e.acc_cyc = 0;
        if (len != 0) begin
            for (int i = 0; i < NB; i++) begin
                e.total += cnt_a[i];
                if (dly_a[i] > mx) mx = dly_a[i];
            end
            e.err = (mx >= DT);
        end
        return e;
    endfunction

    task automatic run(input logic [63:0] seed, input int len, input bit hold);
        exp_t e;
        e = model(seed, len);
        if (hold) hold_until = 1 << 30;
        issue(e);
        if (hold) begin
            for (int n = 0; n < 500; n++) begin
                @(negedge clk);
                if (res_valid) break;
            end
            hold_until = cyc + 10;
        end
        wait_done();
    endtask

    initial begin
        exp_t e;
        int   k;
        cnt_a = '{0, 0, 0, 0};
        dly_a = '{0, 0, 0, 0};
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        cnt_a = '{3, 7, 0, 1};  dly_a = '{20, 20, 20, 20};
        run(64'h1234, 5, 1'b0);
        run({$urandom, $urandom}, 0, 1'b0);
        cnt_a = '{1, 1, 5, 1};  dly_a = '{0, 3, 100000, 2};
        run({$urandom, $urandom}, 6, 1'b0);
        cnt_a = '{9, 8, 7, 6};  dly_a = '{DT-1, 10, 0, 5};
        run({$urandom, $urandom}, 3, 1'b0);
        dly_a = '{DT, 10, 0, 5};
        run({$urandom, $urandom}, 1, 1'b0);
        cnt_a = '{1023, 1023, 1023, 1023}; dly_a = '{4, 1, 2, 3};
        run({$urandom, $urandom}, 4, 1'b1);

        // Reset on the third RUN cycle; the interrupted run must not report.
        e = model({$urandom, $urandom}, 10);
        issue(e);
        k = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (blk_start) k++;
            if (k == 3) break;
        end
        #1 rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        cnt_a = '{3, 7, 0, 1};  dly_a = '{5, 6, 7, 8};
        run({$urandom, $urandom}, 7, 1'b0);

        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < NB; i++) begin
                cnt_a[i] = int'($urandom_range(0, 1023));
                dly_a[i] = ($urandom_range(0, 7) == 0) ? 100000 : int'($urandom_range(0, 40));
            end
            run({$urandom, $urandom}, ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 30)),
                ($urandom_range(0, 5) == 0));
        end

`ifdef DES_RUN_CTRL_ABORT_EN
        cnt_a = '{5, 5, 5, 5};  dly_a = '{100000, 100000, 100000, 100000};
        e = model({$urandom, $urandom}, 4);
        e.total = 0;
        e.err   = 1'b1;
        issue(e);
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (ran && !blk_start && !res_valid && blk_rst_n) break;
        end
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        wait_done();
`endif

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/des_run_ctrl.md
Name: des_run_ctrl

Overview:
- Run controller and result collector for an array of NUM_BLOCKS des_block instances used in linear-cryptanalysis bias counting.
- Accepts a run command (seed, message count) over a valid/ready handshake.
- Clears the blocks, drives their start line for exactly the requested number of cycles, then waits for every block to report valid.
- Sums the per-block 1-counters and returns the total over a valid/ready result handshake.

Parameters:
- NUM_BLOCKS, 4, number of des_block instances driven; legal range 1..16.
- COUNT_W, 10, width of each block's counter output.
- RUN_W, 32, width of the run-length field.
- CLEAR_CYCLES, 2, cycles blk_rst_n is held low before a run; must be ≥1.
- DRAIN_TIMEOUT, 64, maximum DRAIN cycles allowed before the error flag is raised.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  controller can accept a command
- cmd_seed  in  64  message seed
- cmd_run_len  in  RUN_W  number of cycles start is asserted
- blk_rst_n  out  1  active-low reset to all des_blocks
- blk_start  out  1  start to all des_blocks
- blk_seed  out  64*NUM_BLOCKS  seed per block; block i uses slice [64*i+63:64*i]
- blk_counter  in  COUNT_W*NUM_BLOCKS  per-block counters
- blk_valid  in  NUM_BLOCKS  per-block valid flags
- res_valid  out  1  result present
- res_ready  in  1  result consumed
- res_total  out  COUNT_W+4  sum of all block counters
- res_error  out  1  drain timeout or abort occurred

Behaviour:
- States: IDLE, CLEAR, RUN, DRAIN, ACCUM, RESULT.
- Reset values:
  - State is IDLE.
  - blk_start=0, res_valid=0, res_total=0, res_error=0.
  - blk_rst_n=0 while rst=1.
  - cmd_ready=1 from the first cycle after rst is released.
- Reset asserted in any state returns to IDLE and drops blk_start the next cycle. No result is produced for an interrupted run.
- IDLE:
  - cmd_ready=1; blk_rst_n=1.
  - On cmd_valid&&cmd_ready, latch seed and run_len, then go to CLEAR.
  - If the latched run_len=0, go directly to RESULT with total=0 and error=0, and never touch the blocks.
- cmd_ready=0 in every state other than IDLE. cmd_valid is ignored outside IDLE.
- blk_seed for block i = {latched_seed[63:4], i[3:0]}. Bits [3:0] are the block's region select, so regions are disjoint. The value is held constant from CLEAR through ACCUM.
- CLEAR: blk_rst_n=0 for exactly CLEAR_CYCLES cycles, then go to RUN.
- RUN:
  - blk_start=1 for exactly run_len consecutive cycles.
  - The first RUN cycle is the cycle after the last CLEAR cycle.
  - 32-bit down-counter; no wrap. run_len=2^RUN_W-1 is legal.
- DRAIN:
  - blk_start=0 and a timeout counter counts up.
  - Go to ACCUM when all blk_valid bits are 1 in the same cycle.
  - If DRAIN_TIMEOUT cycles elapse first, set the error flag and go to ACCUM anyway.
  - If both happen in the same cycle, valid wins and error is not set.
- ACCUM:
  - One block per cycle, index 0 up to NUM_BLOCKS-1; acc += blk_counter[i].
  - Total latency is NUM_BLOCKS cycles. The accumulator is cleared on command accept.
  - The sum cannot overflow COUNT_W+4 bits for NUM_BLOCKS≤16.
- RESULT:
  - res_valid=1; res_total and res_error are registered and stable while res_valid=1 && res_ready=0.
  - On res_ready=1, go to IDLE next cycle; res_valid drops the same edge.
  - res_ready high before res_valid is permitted and completes in one cycle.
- blk_rst_n=1 in all states except CLEAR and while rst=1.
- Counter wrap inside a des_block is not detected by this controller.

Optional Feature:
- Macro: DES_RUN_CTRL_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit).
  - abort=1 in RUN or DRAIN forces blk_start=0 on the next edge and goes to RESULT with res_total=0 and res_error=1.
  - abort in any other state is ignored.
- Undefined:
  - No abort port.
  - Runs complete only by finishing normally or by drain timeout.

Test Plan:
- Basic run:
  - Stimulus: NUM_BLOCKS=4, cmd_seed=64'h1234, run_len=5, blocks modelled with counters 3,7,0,1, all valid 20 cycles after start falls.
  - Required response: blk_rst_n low 2 cycles; blk_start high exactly 5 cycles; blk_seed[3:0] per block = 0,1,2,3; res_total=11, res_error=0 after 4 ACCUM cycles.
- Zero run_len:
  - Stimulus: run_len=0.
  - Required response: blk_start and blk_rst_n never toggle; res_valid=1 within 2 cycles of accept; res_total=0.
- Timeout:
  - Stimulus: block 2 never raises valid; counters 1,1,5,1.
  - Required response: res_error=1 after 64 DRAIN cycles; res_total=8.
- Backpressure:
  - Stimulus: hold res_ready=0 for 10 cycles.
  - Required response: res_valid, res_total and res_error stable; cmd_ready=0 throughout; IDLE one cycle after res_ready=1.
- Reset mid-run:
  - Stimulus: assert rst on the 3rd RUN cycle.
  - Required response: blk_start=0 and blk_rst_n=0 next cycle; no res_valid; a new command then runs cleanly.
- Abort (DES_RUN_CTRL_ABORT_EN defined):
  - Stimulus: abort in the DRAIN state.
  - Required response: next cycle res_valid=1, res_total=0, res_error=1.
